bit_stream_framer: RTL

//  Write-side source for the 1-bit clock-domain-crossing FIFO. Accepts parallel

---
 rtl/bit_stream_framer_pkg.sv | 20 ++
 rtl/bit_stream_framer_piso_shifter.sv | 28 ++
 rtl/bit_stream_framer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bit_stream_framer_pkg.sv
// Shared types and sizing helpers for the bit-stream framer.
package bit_stream_framer_pkg;

  // Framer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Bit-counter widths for the default geometry (16-bit preamble, 8-bit words).
  localparam int PRE_CNT_W = $clog2(16);
  localparam int DAT_CNT_W = $clog2(8);

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_stream_framer_piso_shifter.sv
// Parallel-in serial-out shifter: parallel load, shift on enable, MSB out first.
module piso_shifter #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  output logic         o_msb
);

  logic [W-1:0] r_sh;

  // Load has priority over shift so a new word can replace the old one on its final bit.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= r_sh << 1;
    end
  end

  assign o_msb = r_sh[W-1];

endmodule

// File: rtl/bit_stream_framer.sv
// Frames payload words behind a fixed preamble and serializes them MSB-first
// into a 1-bit FIFO write port, stalling with zero latency on fifo_full.
module bit_stream_framer
  import bit_stream_framer_pkg::*;
#(
  parameter int                 WORD_W      = 8,
  parameter int                 PRE_LEN     = 16,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = 16'hF0A5,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic              fifo_din,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  // One counter serves both phases, so size it for the longer of the two.
  localparam int BIT_CNT_W = (cnt_width(PRE_LEN) > cnt_width(WORD_W)) ?
                             cnt_width(PRE_LEN) : cnt_width(WORD_W);
  localparam logic [BIT_CNT_W-1:0] PRE_LAST = BIT_CNT_W'(PRE_LEN - 1);
  localparam logic [BIT_CNT_W-1:0] DAT_LAST = BIT_CNT_W'(WORD_W - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
  logic                   r_full;        // word register holds an unsent word
  logic                   w_full_next;
  logic                   r_last;        // held word closes the frame
  logic                   w_last_next;
  logic                   r_frame_done;
  logic                   w_frame_done_next;
  logic [CNT_W-1:0]       r_frame_cnt;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_we;
  logic                   w_din;
  logic                   w_pre_msb;
  logic                   w_dat_msb;
  logic                   w_pre_load;
  logic                   w_pre_shift;
  logic                   w_dat_load;
  logic                   w_dat_shift;

  piso_shifter #(.W(PRE_LEN)) u_pre_shifter (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_load   (w_pre_load),
    .i_data   (PRE_PATTERN),
    .i_shift  (w_pre_shift),
    .o_msb    (w_pre_msb)
  );

  piso_shifter #(.W(WORD_W)) u_dat_shifter (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_load   (w_dat_load),
    .i_data   (s_data),
    .i_shift  (w_dat_shift),
    .o_msb    (w_dat_msb)
  );

  // Next-state, handshake and write-port decode; all advancement is gated by an actual write.
  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt;
    w_full_next       = r_full;
    w_last_next       = r_last;
    w_frame_done_next = 1'b0;
    w_ready           = 1'b0;
    w_accept          = 1'b0;
    w_we              = 1'b0;
    w_din             = 1'b0;

    case (r_state)
      IDLE: begin
        w_ready  = 1'b1;
        w_accept = s_valid;
        if (s_valid) begin
          w_state_next   = PRE;
          w_bit_cnt_next = '0;
          w_full_next    = 1'b1;
          w_last_next    = s_last;
        end
      end

      PRE: begin
        w_we  = !fifo_full;
        w_din = w_pre_msb;
        if (w_we) begin
          if (r_bit_cnt == PRE_LAST) begin
            w_state_next   = DATA;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
          end
        end
      end

      DATA: begin
        w_we     = r_full & !fifo_full;
        w_din    = w_dat_msb;
        // Accept into an empty register, or overlap the next word with the final bit.
        w_ready  = !r_full | (w_we & (r_bit_cnt == DAT_LAST) & !r_last);
        w_accept = s_valid & w_ready;
        if (w_we) begin
          if (r_bit_cnt == DAT_LAST) begin
            w_bit_cnt_next = '0;
            if (r_last) begin
              w_state_next      = IDLE;
              w_full_next       = 1'b0;
              w_last_next       = 1'b0;
              w_frame_done_next = 1'b1;
            end else if (w_accept) begin
              w_full_next = 1'b1;
              w_last_next = s_last;
            end else begin
              w_full_next = 1'b0;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_W'(1);
          end
        end else if (w_accept) begin
          w_full_next    = 1'b1;
          w_last_next    = s_last;
          w_bit_cnt_next = '0;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_pre_load  = (r_state == IDLE) & w_accept;
  assign w_pre_shift = (r_state == PRE) & w_we;
  assign w_dat_load  = w_accept;
  assign w_dat_shift = (r_state == DATA) & w_we;

  // State, counters and the frame-done pulse.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_full       <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_full       <= w_full_next;
      r_last       <= w_last_next;
      r_frame_done <= w_frame_done_next;
      if (w_frame_done_next) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  // s_ready is forced low while reset is asserted even though the state reads IDLE.
  assign s_ready    = w_ready & rst_in_n;
  assign fifo_we    = w_we;
  assign fifo_din   = w_we & w_din;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule
